// File: rtl/lcd_reader_if.sv
// Request/response bundle between a host block and lcd_reader.
// The host drives req/rs_sel/poll; the reader returns busy/done/rd_data/timeout.
interface lcd_reader_if;
    logic       req;
    logic       rs_sel;
    logic       poll;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       timeout;

    modport master (output req, rs_sel, poll, input busy, done, rd_data, timeout);
    modport slave  (input req, rs_sel, poll, output busy, done, rd_data, timeout);
endinterface

// File: rtl/lcd_reader.sv
// HD44780 4-bit read controller: one status or data read (two nibbles, MSB first) per request.
// Define BF_POLL_EN to enable busy-flag polling with a POLL_MAX attempt limit and timeout flag.
module lcd_reader #(
    parameter int T_SETUP  = 2,
    parameter int T_EHIGH  = 25,
    parameter int T_GAP    = 50,
    parameter int POLL_MAX = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    lcd_reader_if.slave  bus,
    input  logic [3:0]   lcd_din,
    output logic [2:0]   control
);

    localparam int T_MAX0 = (T_SETUP > T_EHIGH) ? T_SETUP : T_EHIGH;
    localparam int T_MAX  = (T_MAX0 > T_GAP) ? T_MAX0 : T_GAP;
    localparam int CNT_W  = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_HI,
        EHI_HI,
        GAP_HI,
        SETUP_LO,
        EHI_LO,
        GAP_LO
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               rs_q, rs_n;
    logic [7:0]         rd_q, rd_n;
    logic               done_q, done_n;
    logic               last;

`ifdef BF_POLL_EN
    localparam int ATT_W = $clog2(POLL_MAX + 1);
    logic               poll_q, poll_n;
    logic               timeout_q, timeout_n;
    logic [ATT_W-1:0]   att, att_n;
`else
    logic               unused_poll;
    assign unused_poll = bus.poll;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rs_q      <= 1'b0;
            rd_q      <= 8'h00;
            done_q    <= 1'b0;
`ifdef BF_POLL_EN
            poll_q    <= 1'b0;
            timeout_q <= 1'b0;
            att       <= '0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rs_q      <= rs_n;
            rd_q      <= rd_n;
            done_q    <= done_n;
`ifdef BF_POLL_EN
            poll_q    <= poll_n;
            timeout_q <= timeout_n;
            att       <= att_n;
`endif
        end
    end

    // Each timed state counts down from N-1 and hands over to the next state on zero.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rs_n      = rs_q;
        rd_n      = rd_q;
        done_n    = 1'b0;
        last      = (cnt == '0);
`ifdef BF_POLL_EN
        poll_n    = poll_q;
        timeout_n = timeout_q;
        att_n     = att;
`endif
        if (state != IDLE) begin
            cnt_n = cnt - 1'b1;
        end
        case (state)
            IDLE: begin
                if (bus.req) begin
                    state_n   = SETUP_HI;
                    cnt_n     = CNT_W'(T_SETUP - 1);
                    rs_n      = bus.rs_sel;
`ifdef BF_POLL_EN
                    poll_n    = bus.poll;
                    timeout_n = 1'b0;
                    att_n     = ATT_W'(1);
`endif
                end
            end
            SETUP_HI: if (last) begin
                state_n = EHI_HI;
                cnt_n   = CNT_W'(T_EHIGH - 1);
            end
            EHI_HI: if (last) begin
                state_n   = GAP_HI;
                cnt_n     = CNT_W'(T_GAP - 1);
                rd_n[7:4] = lcd_din;
            end
            GAP_HI: if (last) begin
                state_n = SETUP_LO;
                cnt_n   = CNT_W'(T_SETUP - 1);
            end
            SETUP_LO: if (last) begin
                state_n = EHI_LO;
                cnt_n   = CNT_W'(T_EHIGH - 1);
            end
            EHI_LO: if (last) begin
                state_n   = GAP_LO;
                cnt_n     = CNT_W'(T_GAP - 1);
                rd_n[3:0] = lcd_din;
            end
            GAP_LO: if (last) begin
                state_n = IDLE;
                cnt_n   = '0;
                done_n  = 1'b1;
`ifdef BF_POLL_EN
                // Busy flag still set: re-read status until the attempt budget runs out.
                if (poll_q && !rs_q && rd_q[7]) begin
                    if (att < ATT_W'(POLL_MAX)) begin
                        state_n = SETUP_HI;
                        cnt_n   = CNT_W'(T_SETUP - 1);
                        done_n  = 1'b0;
                        att_n   = att + 1'b1;
                    end else begin
                        timeout_n = 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // RW stays high for the whole transaction so E is never high while the bus is written.
    always_comb begin
        control = 3'b000;
        case (state)
            IDLE:           control = 3'b000;
            EHI_HI, EHI_LO: control = {1'b1, rs_q, 1'b1};
            default:        control = {1'b0, rs_q, 1'b1};
        endcase
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_q;
    assign bus.rd_data = rd_q;
`ifdef BF_POLL_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_reader.sv
// Directed self-checking bench for lcd_reader with a nibble-serving LCD model.
// Poll tests run only when BF_POLL_EN is defined; the default build checks the poll input is ignored.
module tb_lcd_reader;

`ifdef BF_POLL_EN
    localparam int TB_POLL_MAX = 4;
`else
    localparam int TB_POLL_MAX = 1000;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] lcd_din;
    logic [2:0] control;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    logic [3:0] hi_seq [8];
    logic [3:0] lo_nib;
    int         e_cnt   = 0;
    int         e_falls = 0;
    logic       e_prev  = 1'b0;

    lcd_reader_if bus();

    lcd_reader #(
        .T_SETUP (2),
        .T_EHIGH (25),
        .T_GAP   (50),
        .POLL_MAX(TB_POLL_MAX)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .lcd_din(lcd_din),
        .control(control)
    );

    always #10 clk = ~clk;

    // LCD model: data is only valid once E has been high long enough; garbage otherwise.
    always @(negedge clk) begin
        if (!bus.busy) begin
            e_falls = 0;
        end else if (e_prev && !control[2]) begin
            e_falls++;
        end
        e_prev = control[2];
        e_cnt  = control[2] ? e_cnt + 1 : 0;
        if (e_cnt >= 20) begin
            lcd_din = (e_falls % 2 == 0) ? hi_seq[(e_falls / 2) % 8] : lo_nib;
        end else begin
            lcd_din = 4'hA;
        end
        if ((control[0] !== bus.busy) || (control[2] && !control[0])) begin
            viol++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic setNibbles(input logic [3:0] hi, input logic [3:0] lo);
        for (int i = 0; i < 8; i++) hi_seq[i] = hi;
        lo_nib = lo;
    endtask

    // Called at a negedge; req is sampled at the following edge (edge 0).
    task automatic applyStimulus(input logic rs, input logic poll, input logic hold);
        bus.rs_sel = rs;
        bus.poll   = poll;
        bus.req    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req    = 1'b0;
            bus.rs_sel = ~rs;
            bus.poll   = ~poll;
        end
    endtask

    function automatic logic [2:0] expCtrl(input int k, input logic rs);
        if (k <= 1)   return {1'b0, rs, 1'b1};
        if (k <= 26)  return {1'b1, rs, 1'b1};
        if (k <= 78)  return {1'b0, rs, 1'b1};
        if (k <= 103) return {1'b1, rs, 1'b1};
        if (k <= 153) return {1'b0, rs, 1'b1};
        return 3'b000;
    endfunction

    task automatic waitDone(input int budget, input logic chk_table, input logic rs,
                            input int pulse_at, output int cycles, output int rises);
        bit   seen = 0;
        int   bad  = 0;
        logic prev_e = 1'b0;
        cycles = -1;
        rises  = 0;
        for (int k = 0; k <= budget && !seen; k++) begin
            @(negedge clk);
            if (k == pulse_at)     bus.req = 1'b1;
            if (k == pulse_at + 1) bus.req = 1'b0;
            if (control[2] && !prev_e) rises++;
            prev_e = control[2];
            if (chk_table && (control !== expCtrl(k, rs))) bad++;
            if (bus.done) begin
                seen   = 1;
                cycles = k;
            end
        end
        if (chk_table) checkOutput("ctrl_table", bad, 0);
        if (!seen) checkOutput("done_seen", 0, 1);
        else       checkOutput("busy_at_done", bus.busy, 0);
    endtask

    task automatic idleCycles(input int n, output int dn, output int bz);
        dn = 0;
        bz = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy) bz++;
        end
    endtask

    initial begin
        int cyc, rises, dn, bz;
        bus.req    = 1'b0;
        bus.rs_sel = 1'b0;
        bus.poll   = 1'b0;
        rst_n      = 1'b0;
        setNibbles(4'h0, 4'h0);

        repeat (3) @(negedge clk);
        checkOutput("rst_control", control, 3'b000);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_rd_data", bus.rd_data, 8'h00);
        checkOutput("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] data read");
        setNibbles(4'h4, 4'h1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(200, 1'b1, 1'b1, -10, cyc, rises);
        checkOutput("data_latency", cyc, 154);
        checkOutput("data_rd", bus.rd_data, 8'h41);
        checkOutput("data_e_pulses", rises, 2);
        @(negedge clk);
        checkOutput("done_width", bus.done, 0);
        idleCycles(20, dn, bz);
        checkOutput("data_hold", bus.rd_data, 8'h41);
        checkOutput("data_no_extra_done", dn, 0);

        $display("[TB] status read");
        setNibbles(4'h8, 4'h5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        waitDone(200, 1'b1, 1'b0, -10, cyc, rises);
        checkOutput("status_latency", cyc, 154);
        checkOutput("status_rd", bus.rd_data, 8'h85);

        $display("[TB] back-to-back");
        @(negedge clk);
        setNibbles(4'h6, 4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitDone(200, 1'b1, 1'b1, -10, cyc, rises);
        checkOutput("b2b_first_latency", cyc, 154);
        checkOutput("b2b_first_rd", bus.rd_data, 8'h67);
        setNibbles(4'h2, 4'h9);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        waitDone(200, 1'b1, 1'b1, -10, cyc, rises);
        checkOutput("b2b_second_latency", cyc, 154);
        checkOutput("b2b_second_rd", bus.rd_data, 8'h29);

        $display("[TB] req while busy");
        @(negedge clk);
        setNibbles(4'h3, 4'hC);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitDone(200, 1'b1, 1'b1, 60, cyc, rises);
        checkOutput("busy_req_latency", cyc, 154);
        checkOutput("busy_req_rd", bus.rd_data, 8'h3C);
        idleCycles(200, dn, bz);
        checkOutput("busy_req_not_queued", bz, 0);
        checkOutput("busy_req_no_done", dn, 0);

`ifdef BF_POLL_EN
        $display("[TB] poll until clear");
        setNibbles(4'h0, 4'h5);
        hi_seq[0] = 4'h8;
        hi_seq[1] = 4'h8;
        hi_seq[2] = 4'h8;
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone(800, 1'b0, 1'b0, -10, cyc, rises);
        checkOutput("poll_latency", cyc, 616);
        checkOutput("poll_reads", rises, 8);
        checkOutput("poll_rd", bus.rd_data, 8'h05);
        checkOutput("poll_timeout", bus.timeout, 0);

        $display("[TB] poll timeout");
        @(negedge clk);
        setNibbles(4'h8, 4'h5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone(800, 1'b0, 1'b0, -10, cyc, rises);
        checkOutput("poll_to_latency", cyc, 616);
        checkOutput("poll_to_reads", rises, 8);
        checkOutput("poll_to_rd", bus.rd_data, 8'h85);
        checkOutput("poll_to_timeout", bus.timeout, 1);

        @(negedge clk);
        setNibbles(4'hB, 4'hE);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("timeout_cleared", bus.timeout, 0);
        waitDone(800, 1'b1, 1'b1, -10, cyc, rises);
        checkOutput("poll_data_latency", cyc, 154);
        checkOutput("poll_data_rd", bus.rd_data, 8'hBE);
`else
        $display("[TB] poll ignored");
        @(negedge clk);
        setNibbles(4'h8, 4'h5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone(800, 1'b1, 1'b0, -10, cyc, rises);
        checkOutput("nopoll_latency", cyc, 154);
        checkOutput("nopoll_reads", rises, 2);
        checkOutput("nopoll_timeout", bus.timeout, 0);
`endif

        $display("[TB] reset mid-transaction");
        @(negedge clk);
        setNibbles(4'h4, 4'h1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("pre_rst_ehi", control, 3'b111);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_control", control, 3'b000);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_rd_data", bus.rd_data, 8'h00);
        checkOutput("midrst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(200, dn, bz);
        checkOutput("postrst_no_done", dn, 0);
        checkOutput("postrst_idle", bz, 0);

        checkOutput("rw_e_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
